// File: rtl/spi_pkg.sv
// spi_pkg: shared types and CS polarity encodings for the SPI link.
// Revision 1.0
`default_nettype none

package spi_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic CS_ACTIVE_LOW  = 1'b0;
  localparam logic CS_ACTIVE_HIGH = 1'b1;

endpackage

`default_nettype wire

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchronizer for one asynchronous SPI pin.
// Revision 1.0
`default_nettype none

module spi_pin_sync #(
  parameter int   P_SYNC_STAGES = 2,
  parameter logic P_RST_VAL     = 1'b0
) (
  input  logic clk_100,
  input  logic a_rst,
  input  logic pin,
  output logic pin_s
);

  logic [P_SYNC_STAGES-1:0] sync_q;
  logic [P_SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[P_SYNC_STAGES-2:0], pin};
  end

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      sync_q <= {P_SYNC_STAGES{P_RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pin_s = sync_q[P_SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_receiver.sv
// spi_receiver: SPI slave receiver; oversampled pins, MSB-first words out on ready/valid.
// Revision 1.0
`default_nettype none

module spi_receiver
  import spi_pkg::*;
#(
  parameter int P_DATA_WIDTH  = 8,
  parameter int P_CS_POLAR    = 0,
  parameter int P_SAMPLE_EDGE = 1,
  parameter int P_SYNC_STAGES = 2
) (
  input  logic                    clk_100,
  input  logic                    a_rst,
  input  logic                    SCK,
  input  logic                    CS,
  input  logic                    MOSI,
  input  logic                    ready,
  output logic                    valid,
  output logic [P_DATA_WIDTH-1:0] data,
  output logic                    overrun,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int              CNT_W      = $clog2(P_DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(P_DATA_WIDTH - 1);
  localparam logic            CS_ACT     = (P_CS_POLAR != 0) ? CS_ACTIVE_HIGH : CS_ACTIVE_LOW;

  logic sck_s, cs_s, mosi_s;
  logic sck_dly_q, sck_dly_d;

  spi_pin_sync #(.P_SYNC_STAGES(P_SYNC_STAGES), .P_RST_VAL(1'b1)) u_sync_sck (
    .clk_100(clk_100), .a_rst(a_rst), .pin(SCK), .pin_s(sck_s)
  );

  spi_pin_sync #(.P_SYNC_STAGES(P_SYNC_STAGES), .P_RST_VAL(~CS_ACT)) u_sync_cs (
    .clk_100(clk_100), .a_rst(a_rst), .pin(CS), .pin_s(cs_s)
  );

  spi_pin_sync #(.P_SYNC_STAGES(P_SYNC_STAGES), .P_RST_VAL(1'b0)) u_sync_mosi (
    .clk_100(clk_100), .a_rst(a_rst), .pin(MOSI), .pin_s(mosi_s)
  );

  logic cs_active, sample_en;
  assign cs_active = (cs_s == CS_ACT);
  assign sample_en = (P_SAMPLE_EDGE != 0) ? (sck_s && !sck_dly_q) : (!sck_s && sck_dly_q);
  assign sck_dly_d = sck_s;

  state_t                  state_q, state_d;
  logic [P_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    valid_q, valid_d;
  logic [P_DATA_WIDTH-1:0] data_q, data_d;
  logic                    overrun_q, overrun_d;
  logic                    frame_err_q, frame_err_d;
  logic                    word_done;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    valid_d     = valid_q;
    data_d      = data_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    word_done   = 1'b0;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (cs_active) begin
          state_d = RECV;
        end
      end
      RECV: begin
        // CS release takes priority over a coincident sampling edge
        if (!cs_active) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          if (bit_cnt_q != '0) begin
            frame_err_d = 1'b1;
          end
        end else if (sample_en) begin
          shift_d = {shift_q[P_DATA_WIDTH-2:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            word_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      if (!valid_q || ready) begin
        data_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      state_q     <= IDLE;
      sck_dly_q   <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_dly_q   <= sck_dly_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign valid     = valid_q;
  assign data      = data_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == RECV);

endmodule

`default_nettype wire

// File: tb/tb_spi_receiver.sv
// tb_spi_receiver: randomized self-checking bench; default DUT plus a 16-bit falling-edge, CS-high variant.
// Revision 1.0
`default_nettype none

module tb_spi_receiver;

  logic clk_100 = 1'b0;
  logic a_rst   = 1'b1;
  always #5 clk_100 = ~clk_100;

  logic sck_a = 1'b1, cs_a = 1'b1, mosi_a = 1'b0, ready_a = 1'b1;
  logic valid_a, overrun_a, frame_err_a, busy_a;
  logic [7:0] data_a;

  logic sck_b = 1'b1, cs_b = 1'b0, mosi_b = 1'b0, ready_b = 1'b1;
  logic valid_b, overrun_b, frame_err_b, busy_b;
  logic [15:0] data_b;

  spi_receiver u_dut_a (
    .clk_100(clk_100), .a_rst(a_rst), .SCK(sck_a), .CS(cs_a), .MOSI(mosi_a),
    .ready(ready_a), .valid(valid_a), .data(data_a), .overrun(overrun_a),
    .frame_err(frame_err_a), .busy(busy_a)
  );

  spi_receiver #(.P_DATA_WIDTH(16), .P_CS_POLAR(1), .P_SAMPLE_EDGE(0)) u_dut_b (
    .clk_100(clk_100), .a_rst(a_rst), .SCK(sck_b), .CS(cs_b), .MOSI(mosi_b),
    .ready(ready_b), .valid(valid_b), .data(data_b), .overrun(overrun_b),
    .frame_err(frame_err_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: words expected at the consumer, plus expected error-pulse totals
  logic [31:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
  int ovr_a = 0, fe_a = 0, ovr_b = 0, fe_b = 0;
  int exp_ovr_a = 0, exp_fe_a = 0, exp_fe_b = 0;

  always @(negedge clk_100) begin
    if (!a_rst) begin
      if (valid_a && ready_a) got_a.push_back(32'(data_a));
      if (valid_b && ready_b) got_b.push_back(32'(data_b));
      if (overrun_a)   ovr_a++;
      if (frame_err_a) fe_a++;
      if (overrun_b)   ovr_b++;
      if (frame_err_b) fe_b++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic put_bit(input int which, input logic b, input int h);
    if (which == 0) begin
      mosi_a = b; sck_a = 1'b0; #(h * 10); sck_a = 1'b1; #(h * 10);
    end else begin
      mosi_b = b; #(h * 10); sck_b = 1'b0; #(h * 10); sck_b = 1'b1;
    end
  endtask

  task automatic send_word(input int which, input logic [31:0] w, input int width,
                           input int nbits, input int h);
    for (int i = 0; i < nbits; i++) put_bit(which, w[width-1-i], h);
  endtask

  task automatic cs_set(input int which, input bit act);
    if (which == 0) cs_a = act ? 1'b0 : 1'b1;
    else            cs_b = act ? 1'b1 : 1'b0;
  endtask

  task automatic frame_begin(input int which);
    cs_set(which, 1'b1);
    #50;
  endtask

  task automatic frame_end(input int which);
    #40;
    cs_set(which, 1'b0);
    #80;
  endtask

  task automatic drain(input int which);
    logic [31:0] e, g;
    if (which == 0) begin
      while (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        g = (got_a.size() > 0) ? got_a.pop_front() : 'x;
        check("word_a", g, e);
      end
      check("extra_words_a", 32'(got_a.size()), 32'd0);
      got_a.delete();
    end else begin
      while (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        g = (got_b.size() > 0) ? got_b.pop_front() : 'x;
        check("word_b", g, e);
      end
      check("extra_words_b", 32'(got_b.size()), 32'd0);
      got_b.delete();
    end
  endtask

  initial begin
    logic [31:0] w;
    int h, nw;

    #23;
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_data_a",  32'(data_a),  32'd0);
    check("rst_flags_a", {29'd0, overrun_a, frame_err_a, busy_a}, 32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    check("rst_data_b",  32'(data_b),  32'd0);
    @(posedge clk_100); #3 a_rst = 1'b0;
    #50;

    // single word
    frame_begin(0);
    check("busy_in_frame", 32'(busy_a), 32'd1);
    send_word(0, 32'hA5, 8, 8, 3); exp_a.push_back(32'hA5);
    frame_end(0);
    check("busy_after_frame", 32'(busy_a), 32'd0);
    drain(0);

    // back-to-back words in one frame
    frame_begin(0);
    send_word(0, 32'h3C, 8, 8, 2); exp_a.push_back(32'h3C);
    send_word(0, 32'hC3, 8, 8, 2); exp_a.push_back(32'hC3);
    frame_end(0);
    drain(0);
    check("no_err_b2b", 32'(ovr_a + fe_a), 32'd0);

    // backpressure / overrun
    @(posedge clk_100); #1 ready_a = 1'b0;
    frame_begin(0);
    send_word(0, 32'h11, 8, 8, 3);
    send_word(0, 32'h22, 8, 8, 3);
    frame_end(0);
    exp_ovr_a++;
    check("bp_valid_held", 32'(valid_a), 32'd1);
    check("bp_data_held",  32'(data_a),  32'h11);
    check("bp_overrun",    32'(ovr_a),   32'(exp_ovr_a));
    @(posedge clk_100); #1 ready_a = 1'b1;
    @(posedge clk_100); #1;
    check("bp_valid_drop", 32'(valid_a), 32'd0);
    exp_a.push_back(32'h11);
    drain(0);

    // frame error: 5 of 8 bits, then a clean word
    frame_begin(0);
    send_word(0, 32'hFF, 8, 5, 3);
    frame_end(0);
    exp_fe_a++;
    check("ferr_pulse", 32'(fe_a), 32'(exp_fe_a));
    check("ferr_no_valid", 32'(valid_a), 32'd0);
    frame_begin(0);
    send_word(0, 32'h5A, 8, 8, 3); exp_a.push_back(32'h5A);
    frame_end(0);
    drain(0);

    // reset mid-frame with a word held at the output
    @(posedge clk_100); #1 ready_a = 1'b0;
    frame_begin(0);
    send_word(0, 32'h77, 8, 8, 3);
    #40;
    check("held_before_rst", 32'(valid_a), 32'd1);
    send_word(0, 32'hF0, 8, 4, 3);
    #2 a_rst = 1'b1;
    #1;
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_data",  32'(data_a),  32'd0);
    check("midrst_busy",  32'(busy_a),  32'd0);
    cs_set(0, 1'b0); sck_a = 1'b1; mosi_a = 1'b0;
    #30;
    @(posedge clk_100); #3 a_rst = 1'b0; ready_a = 1'b1;
    #50;
    frame_begin(0);
    send_word(0, 32'h81, 8, 8, 3); exp_a.push_back(32'h81);
    frame_end(0);
    drain(0);

    // randomized frames, some aborted mid-word
    for (int f = 0; f < 20; f++) begin
      h  = $urandom_range(2, 5);
      nw = $urandom_range(1, 3);
      frame_begin(0);
      for (int k = 0; k < nw; k++) begin
        w = 32'($urandom_range(0, 255));
        send_word(0, w, 8, 8, h);
        exp_a.push_back(w);
      end
      if ($urandom_range(0, 3) == 0) begin
        send_word(0, 32'($urandom_range(0, 255)), 8, $urandom_range(1, 7), h);
        exp_fe_a++;
      end
      frame_end(0);
    end
    drain(0);
    check("rand_fe_a",  32'(fe_a),  32'(exp_fe_a));
    check("rand_ovr_a", 32'(ovr_a), 32'(exp_ovr_a));

    // variant: 16-bit, CS active high, falling-edge sampling
    frame_begin(1);
    check("busy_b", 32'(busy_b), 32'd1);
    send_word(1, 32'hBEEF, 16, 16, 3); exp_b.push_back(32'hBEEF);
    frame_end(1);
    drain(1);

    for (int f = 0; f < 6; f++) begin
      h = $urandom_range(2, 4);
      frame_begin(1);
      w = 32'($urandom_range(0, 65535));
      send_word(1, w, 16, 16, h); exp_b.push_back(w);
      if (f[0]) begin
        send_word(1, 32'($urandom_range(0, 65535)), 16, $urandom_range(1, 15), h);
        exp_fe_b++;
      end
      frame_end(1);
    end
    drain(1);

    // SCK/MOSI activity with CS inactive must be ignored
    for (int i = 0; i < 12; i++) put_bit(1, 1'($urandom_range(0, 1)), 3);
    #80;
    check("idle_sck_valid_b", 32'(valid_b), 32'd0);
    check("idle_sck_busy_b",  32'(busy_b),  32'd0);
    check("idle_sck_words_b", 32'(got_b.size()), 32'd0);
    check("fe_b_total",  32'(fe_b),  32'(exp_fe_b));
    check("ovr_b_total", 32'(ovr_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
